scsp_midi_out: RTL and testbench

MIDI output transmitter for the SCSP. It is the output-side counterpart of the MIDI input path that feeds MIBUF.
- The sound CPU writes bytes to MOBUF (CR3, 100406). Bytes queue in a small FIFO.
- Bytes are serialised as 8N1 asynchronous frames at 31250 baud on MIDI_TXD.
- The block drives the OE/OF status bits of CR2 and the MIDI-output interrupt request bit into SCIPD/MCIPD.

---
 rtl/scsp_midi_out_pkg.sv | 17 +
 rtl/scsp_midi_fifo.sv | 61 ++++++
 rtl/scsp_midi_out.sv | 131 +++++++++++++
 tb/tb_scsp_midi_out.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/scsp_midi_out_pkg.sv
// Shared types and constants for the SCSP MIDI output transmitter.
`timescale 1ns/1ps
package scsp_midi_out_pkg;

  // 22.5792 MHz / 31250 baud, truncated.
  localparam int unsigned MIDI_BAUD_DIV   = 722;
  localparam int unsigned MIDI_FIFO_DEPTH = 4;

  // One-hot transmitter state.
  typedef enum logic [3:0] {
    MidiTxIdle  = 4'b0001,
    MidiTxStart = 4'b0010,
    MidiTxData  = 4'b0100,
    MidiTxStop  = 4'b1000
  } midi_tx_state_t;

endpackage

// File: rtl/scsp_midi_fifo.sv
// Synchronous byte FIFO for MOBUF; head entry is presented combinationally.
`timescale 1ns/1ps
module scsp_midi_fifo #(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned PtrW = $clog2(DEPTH),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  logic            pop_i,
  input  logic [7:0]      din_i,
  output logic [7:0]      dout_o,
  output logic [CntW-1:0] count_o,
  output logic            empty_o,
  output logic            full_o
);

  logic [7:0]      mem_q [DEPTH];
  logic [PtrW-1:0] rd_q, wr_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pop_ok, push_ok;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CntW'(DEPTH));
  assign dout_o  = mem_q[rd_q];
  assign count_o = cnt_q;

  // A pop on a full FIFO frees the slot a same-cycle push lands in.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  // Occupancy next-state.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push_ok, pop_ok})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage and pointer update; pointers wrap naturally at a power-of-two depth.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_ok) begin
        rd_q <= rd_q + 1'b1;
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/scsp_midi_out.sv
// SCSP MIDI output: MOBUF FIFO feeding an 8N1 serialiser, with CR2 status and IRQ.
`timescale 1ns/1ps
module scsp_midi_out
  import scsp_midi_out_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = MIDI_FIFO_DEPTH,
  parameter int unsigned BAUD_DIV   = MIDI_BAUD_DIV
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       ce_i,
  input  logic       mobuf_wr_i,
  input  logic [7:0] mobuf_di_i,
  output logic       oe_o,
  output logic       of_o,
  output logic       tx_busy_o,
  output logic       irq_mo_o,
  output logic       midi_txd_o
);

  localparam int unsigned CntW  = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BaudW = $clog2(BAUD_DIV);

  midi_tx_state_t   state_q;
  logic [BaudW-1:0] baud_q;
  logic [2:0]       bit_q;
  logic [7:0]       shift_q;
  logic             txd_q;
  logic             irq_q;

  logic [7:0]       fifo_dout;
  logic [CntW-1:0]  fifo_count;
  logic             fifo_empty, fifo_full;
  logic             baud_wrap, pop;

  assign baud_wrap = (baud_q == BaudW'(BAUD_DIV - 1));
  // Pop from idle, or on the last stop tick so frames run back to back.
  assign pop = ce_i && !fifo_empty &&
               ((state_q == MidiTxIdle) || ((state_q == MidiTxStop) && baud_wrap));

  scsp_midi_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (mobuf_wr_i),
    .pop_i   (pop),
    .din_i   (mobuf_di_i),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // Transmitter FSM, baud/bit counters and registered line/IRQ outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= MidiTxIdle;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      irq_q   <= 1'b0;
    end else begin
      // Last byte leaves the FIFO with nothing arriving to replace it.
      irq_q <= pop && (fifo_count == CntW'(1)) && !mobuf_wr_i;
      if (ce_i) begin
        unique case (state_q)
          MidiTxIdle: begin
            if (pop) begin
              state_q <= MidiTxStart;
              shift_q <= fifo_dout;
              baud_q  <= '0;
              txd_q   <= 1'b0;
            end
          end
          MidiTxStart: begin
            if (baud_wrap) begin
              state_q <= MidiTxData;
              baud_q  <= '0;
              bit_q   <= '0;
              txd_q   <= shift_q[0];
            end else begin
              baud_q <= baud_q + 1'b1;
            end
          end
          MidiTxData: begin
            if (baud_wrap) begin
              baud_q <= '0;
              if (bit_q == 3'd7) begin
                state_q <= MidiTxStop;
                txd_q   <= 1'b1;
              end else begin
                bit_q   <= bit_q + 1'b1;
                shift_q <= shift_q >> 1;
                txd_q   <= shift_q[1];
              end
            end else begin
              baud_q <= baud_q + 1'b1;
            end
          end
          MidiTxStop: begin
            if (baud_wrap) begin
              baud_q <= '0;
              if (pop) begin
                state_q <= MidiTxStart;
                shift_q <= fifo_dout;
                txd_q   <= 1'b0;
              end else begin
                state_q <= MidiTxIdle;
              end
            end else begin
              baud_q <= baud_q + 1'b1;
            end
          end
          default: begin
            state_q <= MidiTxIdle;
            txd_q   <= 1'b1;
          end
        endcase
      end
    end
  end

  assign oe_o       = fifo_empty;
  assign of_o       = fifo_full;
  assign tx_busy_o  = (state_q != MidiTxIdle);
  assign irq_mo_o   = irq_q;
  assign midi_txd_o = txd_q;

endmodule

// File: tb/tb_scsp_midi_out.sv
// Self-checking bench for scsp_midi_out: frame-level model plus directed and random stimulus.
`timescale 1ns/1ps
module tb_scsp_midi_out;

  localparam int unsigned B          = 4;
  localparam int unsigned D          = 4;
  localparam int          FrameTicks = 10 * B;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ce = 1'b1;
  logic       wr = 1'b0;
  logic [7:0] di = 8'h00;
  logic       oe, of_w, busy, irq, txd;

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;
  int irq_cnt = 0;
  bit chk_en = 1'b0;

  scsp_midi_out #(
    .FIFO_DEPTH (D),
    .BAUD_DIV   (B)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .ce_i       (ce),
    .mobuf_wr_i (wr),
    .mobuf_di_i (di),
    .oe_o       (oe),
    .of_o       (of_w),
    .tx_busy_o  (busy),
    .irq_mo_o   (irq),
    .midi_txd_o (txd)
  );

  always #5 clk = ~clk;

  // Model: a byte queue and a frame in flight, tracked as a tick offset into the frame.
  logic [7:0] q_m[$];
  bit         busy_m = 1'b0;
  int         tick_m = 0;
  logic [7:0] cur_m = 8'h00;
  bit         irq_m = 1'b0;

  always @(posedge clk) begin : model
    bit pop_m, push_m;
    if (!rst_n) begin
      q_m.delete();
      busy_m = 1'b0;
      tick_m = 0;
      irq_m  = 1'b0;
    end else begin
      pop_m  = ce && (q_m.size() > 0) && (!busy_m || tick_m == FrameTicks - 1);
      push_m = wr && ((q_m.size() < D) || pop_m);
      irq_m  = pop_m && !push_m && (q_m.size() == 1);
      if (ce && busy_m) begin
        if (tick_m == FrameTicks - 1) busy_m = 1'b0;
        else tick_m++;
      end
      if (pop_m) begin
        cur_m  = q_m.pop_front();
        busy_m = 1'b1;
        tick_m = 0;
      end
      if (push_m) q_m.push_back(di);
    end
  end

  // Frame position 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx >= 9) return 1'b1;
    return b[idx-1];
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic step(input logic w, input logic [7:0] d, input logic c, input logic r);
    wr = w; di = d; ce = c; rst_n = r;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b1);
  endtask

  // Advance until the coming edge is the final stop tick of the current frame.
  task automatic wait_final_tick();
    int n = 0;
    while (!(busy_m && tick_m == FrameTicks - 1) && n < 500) begin
      idle(1);
      n++;
    end
    chk("final_tick_reached", n < 500, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || !oe) && n < 1000) begin
      idle(1);
      n++;
    end
    chk("drain_to_idle", n < 1000, 1);
  endtask

  logic [9:0] pat;
  logic [7:0] burst [6];
  int b0, i0, z;

  initial begin
    fork
      begin
        forever begin
          @(negedge clk);
          if (busy) busy_cnt++;
          if (irq) irq_cnt++;
          if (chk_en) begin
            chk("txd", txd, busy_m ? frame_bit(cur_m, tick_m / B) : 1'b1);
            chk("oe", oe, q_m.size() == 0);
            chk("of", of_w, q_m.size() == D);
            chk("tx_busy", busy, busy_m);
            chk("irq", irq, irq_m);
          end
        end
      end
    join_none

    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk_en = 1'b1;
    chk("rst_oe", oe, 1);
    chk("rst_of", of_w, 0);
    chk("rst_busy", busy, 0);
    chk("rst_irq", irq, 0);
    chk("rst_txd", txd, 1);

    // Single byte 0xA5.
    step(1'b1, 8'hA5, 1'b1, 1'b1);
    chk("t1_oe_low", oe, 0);
    idle(1);
    chk("t1_irq_pulse", irq, 1);
    chk("t1_oe_back", oe, 1);
    pat = {1'b1, 8'hA5, 1'b0};
    for (int i = 0; i < 40; i++) begin
      chk("t1_txd_literal", txd, pat[i/4]);
      idle(1);
      if (i == 0) chk("t1_irq_once", irq, 0);
    end
    chk("t1_busy_fall", busy, 0);
    chk("t1_txd_idle", txd, 1);

    // Burst of six writes; the sixth is dropped.
    burst[0] = 8'h90; burst[1] = 8'h3C; burst[2] = 8'h7F;
    burst[3] = 8'h01; burst[4] = 8'h02; burst[5] = 8'h03;
    b0 = busy_cnt; i0 = irq_cnt;
    for (int k = 0; k < 6; k++) begin
      step(1'b1, burst[k], 1'b1, 1'b1);
      if (k == 4) chk("t2_of_full", of_w, 1);
    end
    chk("t2_of_after_drop", of_w, 1);
    wait_idle();
    chk("t2_busy_cycles", busy_cnt - b0, 200);
    chk("t2_irq_count", irq_cnt - i0, 1);

    // Full FIFO, push on the same edge as the stop-tick pop.
    for (int k = 0; k < 5; k++) step(1'b1, 8'hC0 + 8'(k), 1'b1, 1'b1);
    chk("t3_of_full", of_w, 1);
    wait_final_tick();
    step(1'b1, 8'hEE, 1'b1, 1'b1);
    chk("t3_of_held", of_w, 1);
    chk("t3_busy", busy, 1);
    chk("t3_txd_start", txd, 0);
    wait_idle();

    // Alternating CE during a 0xFF frame; a write with CE=0 still queues.
    step(1'b1, 8'hFF, 1'b1, 1'b1);
    idle(1);
    z = 0;
    for (int i = 0; i < 80; i++) begin
      if (txd == 1'b0) z++;
      step(i == 10, 8'h55, (i % 2) == 1, 1'b1);
      if (i == 10) chk("t4_oe_ce0_write", oe, 0);
    end
    chk("t4_start_bit_cycles", z, 8);
    chk("t4_next_frame_start", txd, 0);
    wait_idle();

    // Reset mid-DATA with two bytes queued.
    step(1'b1, 8'h00, 1'b1, 1'b1);
    step(1'b1, 8'h11, 1'b1, 1'b1);
    step(1'b1, 8'h22, 1'b1, 1'b1);
    idle(12);
    chk("t5_pre_busy", busy, 1);
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t5_txd", txd, 1);
    chk("t5_oe", oe, 1);
    chk("t5_busy", busy, 0);
    chk("t5_irq", irq, 0);
    b0 = busy_cnt;
    idle(60);
    chk("t5_no_frames", busy_cnt - b0, 0);

    // Write on the final stop tick with an empty FIFO: one idle cycle gap.
    step(1'b1, 8'h34, 1'b1, 1'b1);
    wait_final_tick();
    step(1'b1, 8'h12, 1'b1, 1'b1);
    chk("t6_gap_busy", busy, 0);
    chk("t6_gap_txd", txd, 1);
    chk("t6_gap_oe", oe, 0);
    idle(1);
    chk("t6_pop_busy", busy, 1);
    chk("t6_pop_txd", txd, 0);
    chk("t6_pop_oe", oe, 1);
    wait_idle();

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 15) == 0, 8'($urandom), $urandom_range(0, 7) != 0,
           $urandom_range(0, 999) != 0);
    end
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
